// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side load/store handshake between the MEM stage and the SRAM controller.
// master = pipeline (issues requests), slave = controller (returns data and ready).
interface mem_sram_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output rd_en, wr_en, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: splits each pipeline word access into BEATS SRAM cycles of
// WAIT_CYCLES clocks each; ready drops for the whole access so the pipeline can freeze.
module mem_sram_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mem_sram_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_we_n
);
    localparam int unsigned BEATS  = DATA_W / SRAM_DW;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [DATA_W-1:0] LANE_MASK = DATA_W'({SRAM_DW{1'b1}});

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic        req;
    logic        last_wait;
    logic        last_beat;
    logic        ready_c;
    logic [31:0] shamt;

    assign req       = bus.rd_en | bus.wr_en;
    assign last_wait = (wait_cnt_q == WAIT_W'(WAIT_CYCLES - 1));
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    assign bus.ready = ready_c;
    assign bus.rdata = rdata_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wait_cnt_d = wait_cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_c    = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        shamt      = 32'(beat_q) * SRAM_DW;

        case (state_q)
            S_IDLE: begin
                ready_c = ~req;
                if (req) begin
                    state_d    = S_ACCESS;
                    op_wr_d    = bus.wr_en;
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    beat_d     = '0;
                    wait_cnt_d = '0;
                end
            end
            S_ACCESS: begin
                // Word index scaled to SRAM locations; wraps silently modulo the SRAM size.
                sram_addr = SRAM_AW'(((addr_q - ADDR_W'(BASE_ADDR)) >> 2) * ADDR_W'(BEATS)
                                     + ADDR_W'(beat_q));
                if (op_wr_q) begin
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = SRAM_DW'(wdata_q >> shamt);
                    // Last clock of a beat releases we_n so address/data hold past the strobe.
                    sram_we_n  = (WAIT_CYCLES == 1) ? 1'b0 : last_wait;
                end else if (last_wait) begin
                    rdata_d = (rdata_q & ~(LANE_MASK << shamt))
                            | (DATA_W'(sram_dq_i) << shamt);
                end

                if (last_wait) begin
                    wait_cnt_d = '0;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                ready_c = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            wait_cnt_q <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wait_cnt_q <= wait_cnt_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule
